// File: rtl/data_memory_responder.sv
// Word-organised data memory behind the execute unit's load/store port: lane-masked
// writes, one-cycle registered reads with write-first forwarding, and a post-reset clear sweep.
module data_memory_responder #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     memory_read_enable,
  input  logic [ADDRESS_WIDTH-1:0] memory_read_address,
  output logic [DATA_WIDTH-1:0]    memory_read_data,
  output logic                     memory_read_valid,
  input  logic                     memory_write_enable,
  input  logic [ADDRESS_WIDTH-1:0] memory_write_address,
  input  logic [DATA_WIDTH-1:0]    memory_write_data,
  input  logic [3:0]               memory_write_mask,
  output logic                     memory_busy,
  output logic                     memory_mask_error
);

  localparam int IW    = ADDRESS_WIDTH - 2;
  localparam int WORDS = 2 ** IW;

  typedef enum logic {CLEAR, READY} state_e;

  state_e                state_q;
  logic [IW-1:0]         clear_idx_q;
  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  logic [IW-1:0]         read_idx;
  logic [IW-1:0]         write_idx;
  logic                  mask_ok;
  logic                  mask_bad;
  logic                  lane_write;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  mem_we;
  logic [IW-1:0]         mem_idx;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_lanes;
  logic                  unused_addr_bits;

  assign read_idx         = memory_read_address[ADDRESS_WIDTH-1:2];
  assign write_idx        = memory_write_address[ADDRESS_WIDTH-1:2];
  assign unused_addr_bits = ^{memory_read_address[1:0], memory_write_address[1:0]};

  // Only naturally aligned byte, half and full-word lane groups are accepted.
  always_comb begin
    mask_ok = 1'b0;
    case (memory_write_mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: mask_ok = 1'b1;
      default:                   mask_ok = 1'b0;
    endcase
  end

  assign mask_bad   = (memory_write_mask != 4'b0000) && !mask_ok;
  assign lane_write = (state_q == READY) && memory_write_enable && mask_ok;

  // Write-first: a same-word write in this cycle overlays its lanes on the returned word.
  always_comb begin
    rd_word = mem_q[read_idx];
    if (lane_write && (write_idx == read_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (memory_write_mask[i]) rd_word[8*i +: 8] = memory_write_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = write_idx;
    mem_wdata = memory_write_data;
    mem_lanes = memory_write_mask;
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_we    = 1'b1;
        mem_idx   = clear_idx_q;
        mem_wdata = '0;
        mem_lanes = 4'b1111;
      end else if (lane_write) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_lanes[i]) mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= CLEAR;
      clear_idx_q       <= '0;
      memory_busy       <= 1'b1;
      memory_read_data  <= '0;
      memory_read_valid <= 1'b0;
      memory_mask_error <= 1'b0;
    end else begin
      memory_read_valid <= 1'b0;
      memory_mask_error <= 1'b0;
      case (state_q)
        CLEAR: begin
          clear_idx_q <= clear_idx_q + IW'(1);
          if (&clear_idx_q) begin
            state_q     <= READY;
            memory_busy <= 1'b0;
          end
        end
        READY: begin
          if (memory_read_enable) begin
            memory_read_valid <= 1'b1;
            memory_read_data  <= rd_word;
          end
          memory_mask_error <= memory_write_enable && mask_bad;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

endmodule
